// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared state encoding and constants for the fetch front end.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [0:0]  S_FILL   = 1'b0;
  localparam logic [0:0]  S_RUN    = 1'b1;

  localparam int          INST_W   = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          BYTE_OFF = 2;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf : one-entry holding register for a stalled ROM word.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] rom_rdata,
  output logic              skid_valid,
  output logic [INST_W-1:0] inst_data
);

  logic              skid_valid_d, skid_valid_q;
  logic [INST_W-1:0] skid_data_d,  skid_data_q;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (clear) begin
      skid_valid_d = 1'b0;
    end else if (load) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rom_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign skid_valid = skid_valid_q;
  // The ROM has already moved on once the skid is loaded, so it must win.
  assign inst_data  = skid_valid_q ? skid_data_q : rom_rdata;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : instruction fetch front end with skid buffer and redirect.
//              Optional perf counters enabled by FETCH_PERF_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_raddr,
  input  logic [INST_W-1:0] rom_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_pc,
  output logic [INST_W-1:0] inst_data
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  logic [0:0]  state_d,    state_q;
  logic [31:0] fetch_pc_d, fetch_pc_q;
  logic [31:0] pc_d,       pc_q;
  logic        skid_load,  skid_clear;
  logic        skid_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'd3;
      state_d    = S_FILL;
      skid_clear = 1'b1;
    end else if (state_q == S_FILL) begin
      state_d    = S_RUN;
      pc_d       = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else if (inst_ready) begin
      pc_d       = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
      skid_clear = skid_valid;
    end else if (!skid_valid) begin
      // First stall cycle: capture mem[pc] before the ROM shows mem[fetch_pc].
      skid_load  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .rom_rdata  (rom_rdata),
    .skid_valid (skid_valid),
    .inst_data  (inst_data)
  );

  assign rom_raddr  = fetch_pc_q[ADDR_W+BYTE_OFF-1:BYTE_OFF];
  assign inst_valid = (state_q == S_RUN);
  assign inst_pc    = pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_d, perf_fetched_q;
  logic [31:0] perf_stall_d,   perf_stall_q;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (inst_valid && inst_ready && !redirect_valid) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (inst_valid && !inst_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. It drives the read address of the synchronous, 1-cycle-latency instruction ROM and consumes its read data.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Handles decode back-pressure with a 1-entry skid buffer, because the ROM has no read enable. Branch redirect restarts fetch.

Parameters:
- ADDR_W, 8, ROM word-address width; ROM depth = 2**ADDR_W words.
- RESET_PC, 32'h0000_0000, byte PC fetched after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_raddr  out  ADDR_W  ROM word address; always equals fetch_pc[ADDR_W+1:2], driven directly from a register.
- rom_rdata  in  32  ROM data; equals mem[rom_raddr sampled at the previous edge].
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored, forced to 0.
- inst_valid  out  1  instruction on inst_* is valid.
- inst_ready  in  1  decode accepts.
- inst_pc  out  32  byte PC of the presented instruction.
- inst_data  out  32  instruction word; skid_data when skid_valid, else rom_rdata.

Behaviour:
- Registers: state {S_FILL, S_RUN}, fetch_pc[31:0], pc_q[31:0], skid_valid, skid_data[31:0].
- inst_valid = (state==S_RUN); inst_pc = pc_q.
- Reset (rst=1 at an edge):
  - state<=S_FILL, fetch_pc<=RESET_PC, pc_q<=RESET_PC, skid_valid<=0.
  - Outputs: inst_valid=0, rom_raddr=RESET_PC[ADDR_W+1:2].
  - Reset mid-stall discards the skid contents.
- S_FILL (ROM latching mem[fetch_pc]):
  - Next edge: state<=S_RUN, pc_q<=fetch_pc, fetch_pc<=fetch_pc+4.
- S_RUN invariant: fetch_pc == pc_q+4.
  - If skid_valid=0, rom_rdata == mem[pc_q].
  - If skid_valid=1, skid_data == mem[pc_q] and rom_rdata == mem[fetch_pc] from the second stall cycle onward.
- S_RUN, skid_valid=0, inst_ready=1: pc_q<=fetch_pc, fetch_pc<=fetch_pc+4. Throughput 1/cycle.
- S_RUN, skid_valid=0, inst_ready=0: skid_data<=rom_rdata, skid_valid<=1, fetch_pc held.
- S_RUN, skid_valid=1, inst_ready=0: hold all state.
- S_RUN, skid_valid=1, inst_ready=1: skid_valid<=0, pc_q<=fetch_pc, fetch_pc<=fetch_pc+4. The next cycle shows rom_rdata with no bubble.
- redirect_valid=1 (any state, highest priority below rst):
  - fetch_pc<={redirect_pc[31:2],2'b00}, skid_valid<=0, state<=S_FILL.
  - The instruction presented that cycle is dropped whether or not inst_ready=1.
  - Latency: redirect at edge t gives inst_valid at cycle t+2 with inst_pc=redirect_pc; exactly one bubble cycle.
  - Redirect during S_FILL re-targets and stays in S_FILL.
- Wrap-around:
  - fetch_pc is a full 32-bit +4 and wraps at 2^32.
  - rom_raddr wraps modulo 2**ADDR_W naturally; inst_pc keeps the full 32-bit value.
- Exactly-once delivery: no instruction is lost or duplicated across any stall pattern without redirect.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output perf_fetched[31:0], counting handshakes (inst_valid&&inst_ready&&!redirect_valid).
  - Adds output perf_stall[31:0], counting cycles with inst_valid&&!inst_ready.
  - Both counters reset to 0 on rst, wrap at 2^32, and have no effect on fetch behaviour.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - State encoding S_FILL=1'b0, S_RUN=1'b1.
  - INST_W=32, PC_STEP=4, BYTE_OFF=2.
- One natural sub-module, fetch_skid_buf: skid_valid/skid_data registers plus the inst_data mux, with load/clear/bypass controls.

Test Plan:
ROM image mem[k]=32'hA000_0000+k.
1. Reset released, inst_ready=1 constant:
   - Cycle 1 after reset: inst_valid=1, inst_pc=0x0, inst_data=A0000000.
   - Then pc 0x4/A0000001, 0x8/A0000002 on consecutive cycles.
2. inst_ready=0 for 3 cycles while inst_pc=0x8:
   - inst_pc=0x8 and inst_data=A0000002 held all 3 cycles.
   - After ready rises, the next cycle shows 0xC/A0000003; no gap or duplicate.
3. redirect_valid with redirect_pc=0x43 while 0x10 is presented:
   - Next cycle inst_valid=0.
   - Following cycle inst_pc=0x40, inst_data=A0000010.
   - 0x10 is never re-presented.
4. Redirect to 0x40 while skid is full and inst_ready=0:
   - Skid is cleared.
   - First valid output is 0x40/A0000010 two cycles later.
5. Redirect to 0x3FC with ADDR_W=8:
   - Sequence 0x3FC/A00000FF, then 0x400/A0000000 (rom_raddr wrapped to 0).
6. rst=1 for one cycle during a stall with skid full:
   - inst_valid=0 next cycle.
   - Then 0x0/A0000000.
   - With FETCH_PERF_EN, perf counters read 0.
